prog_loader: RTL and testbench

- Writable 16-word x 8-bit program memory that replaces the fixed instruction ROM of the 4-bit CPU.
- A byte-stream writer fills the memory through a valid/ready interface. The CPU fetch port (AD -> Q) reads it combinationally.
- The block gates CPU execution through CPU_RUN. The top level holds the program counter and registers cleared while CPU_RUN=0.

---
 rtl/prog_loader.sv | 172 +++++++++++++++++
 tb/tb_prog_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: writable 2**AW x DW program memory filled by a byte stream, gating CPU execution.
// Latency: a transfer lands in memory at the accepting posedge; Q is a combinational read of AD.
// Backpressure: DIN_READY is high only in LOAD; bytes offered in IDLE or RUN are never accepted.
//
// Ports:
//   CK, RST_N             clock (posedge) and asynchronous active-low reset
//   START                 load request; restarts the write pointer from any state
//   DIN/DIN_VALID/DIN_READY  program byte stream, transfer when VALID and READY
//   AD -> Q               CPU fetch port, combinational, no read-during-write forwarding
//   CPU_RUN               CPU may execute (state RUN)
//   DONE                  one-cycle pulse when a load completes
//   ERR                   checksum failure flag
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte
// per load. Without it every load is exactly 2**AW bytes and ERR is constant 0.

module prog_loader #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [DW-1:0] DIN,
    input  logic          DIN_VALID,
    output logic          DIN_READY,
    input  logic [AW-1:0] AD,
    output logic [DW-1:0] Q,
    output logic          CPU_RUN,
    output logic          DONE,
    output logic          ERR
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW-1:0] WP_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] wp;
    logic [DW-1:0] mem [DEPTH];
    logic          done_q;
    logic          xfer;
    logic          we;
    logic          wp_is_last;

    // A transfer is only possible while loading; READY is decoded from state.
    assign xfer       = DIN_VALID && (state == LOAD);
    assign wp_is_last = (wp == WP_LAST);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DW-1:0] sum;
    logic          cs_phase;   // 0: data bytes, 1: next byte is the checksum
    logic [DW-1:0] sum_nxt;
    logic          err_q;

    assign sum_nxt = sum + DIN;
    // The checksum byte is consumed but never stored.
    assign we      = xfer && !cs_phase;
    assign ERR     = err_q;
`else
    assign we      = xfer;
    assign ERR     = 1'b0;
`endif

    // Control FSM: state, write pointer, DONE pulse (and checksum tracking).
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            wp       <= '0;
            done_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum      <= '0;
            cs_phase <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state    <= LOAD;
                        wp       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum      <= '0;
                        cs_phase <= 1'b0;
                        err_q    <= 1'b0;
`endif
                    end
                end

                LOAD: begin
                    if (START) begin
                        // Restart wins over a coincident transfer: the byte has
                        // already been written at the old pointer by the memory
                        // process, but it never counts as the final byte.
                        wp       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum      <= '0;
                        cs_phase <= 1'b0;
`endif
                    end else if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum <= sum_nxt;
                        if (cs_phase) begin
                            cs_phase <= 1'b0;
                            // Sum of all data bytes plus the checksum must be zero.
                            if (sum_nxt == '0) begin
                                state  <= RUN;
                                done_q <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                err_q  <= 1'b1;
                            end
                        end else begin
                            wp <= wp + 1'b1;
                            if (wp_is_last) begin
                                cs_phase <= 1'b1;
                            end
                        end
`else
                        wp <= wp + 1'b1;
                        if (wp_is_last) begin
                            state  <= RUN;
                            done_q <= 1'b1;
                        end
`endif
                    end
                end

                RUN: begin
                    // DIN_VALID is ignored here; memory is kept until overwritten.
                    if (START) begin
                        state    <= LOAD;
                        wp       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum      <= '0;
                        cs_phase <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    wp    <= '0;
                end
            endcase
        end
    end

    // Program memory: cleared by reset so a load interrupted by reset leaves
    // no stale partial image behind.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wp] <= DIN;
        end
    end

    assign Q         = mem[AD];
    assign DIN_READY = (state == LOAD);
    assign CPU_RUN   = (state == RUN);
    assign DONE      = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed stimulus for prog_loader against a byte-count model.
// Latency: outputs checked 1 ns after every posedge the bench drives.
// Backpressure: the bench offers bytes regardless of DIN_READY; the model decides acceptance.
`timescale 1ns/1ps

module tb_prog_loader;

    localparam int AW = 4;
    localparam int DW = 8;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic          CK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic          DIN_VALID = 1'b0;
    logic          DIN_READY;
    logic [AW-1:0] AD = '0;
    logic [DW-1:0] Q;
    logic          CPU_RUN;
    logic          DONE;
    logic          ERR;

    always #5 CK = ~CK;

    prog_loader #(.AW(AW), .DW(DW)) dut (
        .CK(CK), .RST_N(RST_N), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY), .AD(AD), .Q(Q), .CPU_RUN(CPU_RUN), .DONE(DONE), .ERR(ERR)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=loading 2=running; m_cnt = bytes accepted
    // since the last (re)start of the load.
    int         m_mode;
    int         m_cnt;
    int         m_sum;
    bit         m_done;
    bit         m_err;
    logic [7:0] m_mem [16];
    int         xfer_cnt;
    logic [7:0] img [16];

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_sum = 0; m_done = 0; m_err = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    endtask

    task automatic model_step(input bit st, input bit vld, input logic [7:0] d);
        m_done = 0;
        if (m_mode == 0) begin
            if (st) begin m_mode = 1; m_cnt = 0; m_sum = 0; m_err = 0; end
        end else if (m_mode == 1) begin
            if (vld) begin
                xfer_cnt++;
                if (m_cnt < 16) m_mem[m_cnt] = d;
            end
            if (st) begin
                m_cnt = 0; m_sum = 0;
            end else if (vld) begin
                m_sum = (m_sum + int'(d)) % 256;
                m_cnt++;
                if (m_cnt == NB) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (m_sum == 0) begin m_mode = 2; m_done = 1; end
                    else begin m_mode = 0; m_err = 1; end
`else
                    m_mode = 2; m_done = 1;
`endif
                end
            end
        end else begin
            if (st) begin m_mode = 1; m_cnt = 0; m_sum = 0; end
        end
    endtask

    task automatic check_outputs();
        chk("din_ready", {31'b0, DIN_READY}, {31'b0, m_mode == 1});
        chk("cpu_run",   {31'b0, CPU_RUN},   {31'b0, m_mode == 2});
        chk("done",      {31'b0, DONE},      {31'b0, m_done});
        chk("err",       {31'b0, ERR},       {31'b0, m_err});
        chk("q",         {24'b0, Q},         {24'b0, m_mem[AD]});
    endtask

    // One clock: drive inputs, advance the model, check 1 ns after the edge.
    task automatic cycle(input bit st, input bit vld, input logic [7:0] d);
        START = st; DIN_VALID = vld; DIN = d; AD = 4'($urandom);
        model_step(st, vld, d);
        @(posedge CK); #1;
        check_outputs();
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
        AD = a; #0.1;
        chk(tag, {24'b0, Q}, {24'b0, exp});
    endtask

    task automatic do_reset();
        START = 0; DIN_VALID = 0; RST_N = 0; #1;
        model_reset();
        chk("rst_ready", {31'b0, DIN_READY}, 0);
        chk("rst_run",   {31'b0, CPU_RUN},   0);
        chk("rst_done",  {31'b0, DONE},      0);
        chk("rst_err",   {31'b0, ERR},       0);
        for (int a = 0; a < 16; a++) peek("rst_q", 4'(a), 8'h00);
        @(negedge CK); RST_N = 1;
        @(posedge CK); #1;
        check_outputs();
    endtask

    // START, then the 16-byte image (plus checksum if enabled), optionally
    // with DIN_VALID low every other cycle carrying junk data.
    task automatic load_img(input bit throttle, output int rdy_cnt, output int done_cnt,
                            output int xf_at_done);
        int         k;
        int         s;
        bit         vld;
        logic [7:0] b;
        logic [7:0] cs;
        s = 0;
        for (int i = 0; i < 16; i++) s += int'(img[i]);
        cs = 8'(256 - (s % 256));
        rdy_cnt = 0; done_cnt = 0; xf_at_done = -1; k = 0;
        cycle(1, 0, 8'h00);
        xfer_cnt = 0;
        for (int i = 0; i < (throttle ? 2 * NB : NB) + 2; i++) begin
            vld = throttle ? (i % 2 == 0) : 1'b1;
            if (k >= NB) vld = 0;
            b = (k < 16) ? img[k] : cs;
            if (!vld) b = 8'($urandom);
            if (DIN_READY) rdy_cnt++;
            cycle(0, vld, b);
            if (vld) k++;
            if (DONE) begin done_cnt++; xf_at_done = xfer_cnt; end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, dc, xd;
        xfer_cnt = 0;
        model_reset();
        do_reset();

        // Back-to-back load of the reference program.
        img = '{8'hA8, 8'h00, 8'hA4, 8'h00, 8'hA2, 8'h00, 8'hA1, 8'h00,
                8'hA2, 8'h00, 8'hA4, 8'hB0, 8'h00, 8'h00, 8'h00, 8'h00};
        load_img(0, rc, dc, xd);
        chk("b2b_ready_cycles", rc, NB);
        chk("b2b_done_count", dc, 1);
        chk("b2b_done_after", xd, NB);
        chk("b2b_cpu_run", {31'b0, CPU_RUN}, 1);
        peek("b2b_q0", 4'd0, 8'hA8);
        peek("b2b_q11", 4'd11, 8'hB0);
        peek("b2b_q15", 4'd15, 8'h00);

        // Throttled load into a freshly cleared memory.
        do_reset();
        load_img(1, rc, dc, xd);
        chk("thr_done_count", dc, 1);
        chk("thr_done_after", xd, NB);
        chk("thr_cpu_run", {31'b0, CPU_RUN}, 1);
        for (int a = 0; a < 16; a++) peek("thr_img", 4'(a), img[a]);

        // Restart after 5 bytes, then a full image 11..20.
        cycle(1, 0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h55 + i));
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h11 + i);
        load_img(0, rc, dc, xd);
        chk("rst_done_after", xd, NB);
        chk("rst_done_count", dc, 1);
        peek("restart_q0", 4'd0, 8'h11);

        // Reload from RUN: old contents stay readable, then reset wipes it.
        cycle(1, 0, 8'h00);
        chk("reload_run_low", {31'b0, CPU_RUN}, 0);
        chk("reload_ready", {31'b0, DIN_READY}, 1);
        peek("reload_q0", 4'd0, 8'h11);
        peek("reload_q5", 4'd5, 8'h16);
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'($urandom));
        do_reset();

        // START coincident with a transfer: byte lands, pointer restarts.
        cycle(1, 0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h3C);
        cycle(1, 1, 8'h77);
        peek("coinc_q3", 4'd3, 8'h77);
        cycle(0, 1, 8'h5A);
        peek("coinc_q0", 4'd0, 8'h5A);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Good checksum: 16 x 01 + F0.
        for (int i = 0; i < 16; i++) img[i] = 8'h01;
        load_img(0, rc, dc, xd);
        chk("cs_good_done", dc, 1);
        chk("cs_good_run", {31'b0, CPU_RUN}, 1);
        // Bad checksum: 16 x 01 + F1.
        cycle(1, 0, 8'h00);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'h01);
        cycle(0, 1, 8'hF1);
        chk("cs_bad_err", {31'b0, ERR}, 1);
        chk("cs_bad_run", {31'b0, CPU_RUN}, 0);
        chk("cs_bad_done", {31'b0, DONE}, 0);
        chk("cs_bad_idle", {31'b0, DIN_READY}, 0);
        cycle(0, 1, 8'h00);
        chk("cs_err_hold", {31'b0, ERR}, 1);
        cycle(1, 0, 8'h00);
        chk("cs_err_clear", {31'b0, ERR}, 0);
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
